// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-memory responder and the
//                control unit: state encoding, width defaults, operation
//                type and the load/store opcode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Width defaults shared by the datapath and the memory
    localparam int c_DATA_W_DEFAULT = 32;
    localparam int c_ADDR_W_DEFAULT = 8;

    // Responder FSM encoding
    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    // Primary opcodes that the control unit routes to the data memory
    localparam logic [5:0] c_OP_LOAD  = 6'b100011;
    localparam logic [5:0] c_OP_STORE = 6'b101011;

    // Latched access type
    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } memOp_t;

    // True when the opcode addresses the data memory
    function automatic logic isMemOpcode(input logic [5:0] opcode);
        return (opcode == c_OP_LOAD) || (opcode == c_OP_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : Word-addressed storage for the data-memory responder.
//                Synchronous write, combinational read, no reset.
//  Ports       : clk        - clock
//                i_wrEn     - write enable, commits on rising edge
//                i_wrAddr   - write word index
//                i_wrData   - write data
//                i_rdAddr   - read word index
//                o_rdData   - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-memory responder. Accepts one load or store in IDLE,
//                waits WAIT_CYCLES cycles, then performs the access in RESP
//                and pulses MemDone. Illegal requests pulse MemError.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous, active-high
//                MemToRead  - read request strobe
//                MemToWrite - write request strobe
//                Address    - byte address
//                WriteData  - store data
//                ReadData   - registered load data
//                MemReady   - high in IDLE
//                MemDone    - one-cycle completion pulse
//                MemError   - one-cycle pulse on a rejected request
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W_DEFAULT,
    parameter int ADDR_W      = c_ADDR_W_DEFAULT,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemToRead,
    input  logic              MemToWrite,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemDone,
    output logic              MemError
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_nextState;
    logic [3:0]           r_waitCount;
    memOp_t               r_op;
    logic [ADDR_W-1:0]    r_idx;
    logic [DATA_W-1:0]    r_wrData;
    logic [DATA_W-1:0]    r_readData;
    logic                 r_memError;

    logic                 w_anyReq;
    logic                 w_bothReq;
    logic                 w_misaligned;
    logic                 w_outOfRange;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_waitDone;
    logic                 w_pendingRead;
    logic                 w_loadReadData;
    logic                 w_arrayWe;
    logic [ADDR_W-1:0]    w_reqIdx;
    logic [ADDR_W-1:0]    w_rdIdx;
    logic [DATA_W-1:0]    w_arrayRdData;

    // ------------------------------------------------------------------
    // Request decode and address check
    // ------------------------------------------------------------------
    assign w_anyReq     = MemToRead | MemToWrite;
    assign w_bothReq    = MemToRead & MemToWrite;
    assign w_misaligned = |Address[1:0];
    assign w_reqIdx     = Address[ADDR_W+1:2];

    generate
        if (ADDR_W + 2 < 32) begin : g_rangeCheck
            assign w_outOfRange = |Address[31:ADDR_W+2];
        end else begin : g_noRangeCheck
            assign w_outOfRange = 1'b0;
        end
    endgenerate

    assign w_accept = (r_state == c_ST_IDLE) && w_anyReq && !w_bothReq
                      && !w_misaligned && !w_outOfRange;
    assign w_reject = (r_state == c_ST_IDLE) && w_anyReq && !w_accept;

    // Counter holds the number of WAIT cycles already completed
    assign w_waitDone = (({1'b0, r_waitCount} + 5'd1) == 5'(WAIT_CYCLES));

    // With no wait cycles the read happens on the accepting edge, so the
    // array must see the incoming index and op rather than the latched ones.
    assign w_rdIdx        = (r_state == c_ST_IDLE) ? w_reqIdx : r_idx;
    assign w_pendingRead  = (r_state == c_ST_IDLE) ? MemToRead : (r_op == MEM_OP_READ);
    assign w_loadReadData = (w_nextState == c_ST_RESP) && w_pendingRead;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = (WAIT_CYCLES == 0) ? c_ST_RESP : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_waitDone) begin
                    w_nextState = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_nextState = c_ST_IDLE;
            end
            default: begin
                w_nextState = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        MemReady  = (r_state == c_ST_IDLE);
        MemDone   = (r_state == c_ST_RESP);
        w_arrayWe = (r_state == c_ST_RESP) && (r_op == MEM_OP_WRITE);
        MemError  = r_memError;
        ReadData  = r_readData;
    end

    // ------------------------------------------------------------------
    // Request latches and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitCount <= 4'd0;
            r_op        <= MEM_OP_READ;
            r_idx       <= '0;
            r_wrData    <= '0;
        end else if (w_accept) begin
            r_waitCount <= 4'd0;
            r_op        <= MemToWrite ? MEM_OP_WRITE : MEM_OP_READ;
            r_idx       <= w_reqIdx;
            r_wrData    <= WriteData;
        end else if (r_state == c_ST_WAIT) begin
            r_waitCount <= r_waitCount + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memError <= 1'b0;
            r_readData <= '0;
        end else begin
            r_memError <= w_reject;
            if (w_loadReadData) begin
                r_readData <= w_arrayRdData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .i_wrEn   (w_arrayWe),
        .i_wrAddr (r_idx),
        .i_wrData (r_wrData),
        .i_rdAddr (w_rdIdx),
        .o_rdData (w_arrayRdData)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Directed self-checking bench for data_mem_responder.
//                u_dut uses one wait cycle, u_dut0 uses none.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemToRead, MemToWrite;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemReady, MemDone, MemError;

    logic        rd0, wr0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, done0, err0;

    int nAssert = 0;
    int nFail   = 0;

    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .MemToRead  (MemToRead),
        .MemToWrite (MemToWrite),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .MemReady   (MemReady),
        .MemDone    (MemDone),
        .MemError   (MemError)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .MemToRead  (rd0),
        .MemToWrite (wr0),
        .Address    (addr0),
        .WriteData  (wdata0),
        .ReadData   (rdata0),
        .MemReady   (ready0),
        .MemDone    (done0),
        .MemError   (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete access on u_dut, starting and ending at a negedge in IDLE.
    // WriteData is replaced by lateData once the request has been accepted.
    task automatic doAccess(input bit isWrite, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] lateData,
                            input string tag);
        int cycles;
        int readyLow;
        int errSeen;
        MemToWrite = isWrite;
        MemToRead  = !isWrite;
        Address    = addr;
        WriteData  = data;
        @(negedge clk);
        MemToWrite = 1'b0;
        MemToRead  = 1'b0;
        WriteData  = lateData;
        Address    = 32'hFFFF_FFFF;
        cycles   = 1;
        readyLow = MemReady ? 0 : 1;
        errSeen  = MemError ? 1 : 0;
        while (!MemDone && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (!MemReady) readyLow++;
            if (MemError)  errSeen++;
        end
        checkValue({tag, "_latency"}, cycles, 2);
        if (!isWrite) checkValue({tag, "_rdata"}, ReadData, data);
        @(negedge clk);
        checkValue({tag, "_readyBack"}, {31'd0, MemReady}, 1);
        checkValue({tag, "_readyLow"}, readyLow, 2);
        checkValue({tag, "_noErr"}, errSeen, 0);
    endtask

    // One illegal request on u_dut held for a single sampling edge.
    task automatic doReject(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] prevRead, input string tag);
        MemToRead  = rd;
        MemToWrite = wr;
        Address    = addr;
        WriteData  = 32'h5A5A_0000;
        @(negedge clk);
        MemToRead  = 1'b0;
        MemToWrite = 1'b0;
        checkValue({tag, "_err"},   {31'd0, MemError}, 1);
        checkValue({tag, "_ready"}, {31'd0, MemReady}, 1);
        checkValue({tag, "_done"},  {31'd0, MemDone},  0);
        @(negedge clk);
        checkValue({tag, "_errPulse"}, {31'd0, MemError}, 0);
        checkValue({tag, "_done2"},    {31'd0, MemDone},  0);
        checkValue({tag, "_rdKeep"},   ReadData, prevRead);
    endtask

    initial begin
        int first;
        int second;
        int doneCnt;
        reset = 1'b1;
        MemToRead = 1'b0; MemToWrite = 1'b0; Address = '0; WriteData = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        checkValue("rst_rdata", ReadData, 32'h0);
        checkValue("rst_ready", {31'd0, MemReady}, 1);
        checkValue("rst_done",  {31'd0, MemDone},  0);
        checkValue("rst_err",   {31'd0, MemError}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read
        doAccess(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, "wr10");
        doAccess(1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, "rd10");

        // Both strobes: rejected, memory keeps the earlier value
        doAccess(1'b1, 32'h20, 32'hCAFE_F00D, 32'h0, "wr20");
        doReject(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, "both20");
        doAccess(1'b0, 32'h20, 32'hCAFE_F00D, 32'h0, "rd20");

        // Misaligned 0x13 would hit word 0x10; out-of-range 0x400 word 0x0
        doAccess(1'b1, 32'h0, 32'h0BAD_F00D, 32'h0, "wr00");
        doReject(1'b0, 1'b1, 32'h13,  32'hCAFE_F00D, "mis13");
        doReject(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D, "oor400");
        doAccess(1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, "rd10b");
        doAccess(1'b0, 32'h0,  32'h0BAD_F00D, 32'h0, "rd00");

        // Write data is latched at acceptance
        doAccess(1'b1, 32'h04, 32'h1, 32'h2, "wr04");
        doAccess(1'b0, 32'h04, 32'h1, 32'h0, "rd04");

        // Held read strobe: back-to-back accesses every three cycles
        MemToRead = 1'b1;
        Address   = 32'h04;
        first  = -1;
        second = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (MemDone) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        MemToRead = 1'b0;
        @(negedge clk);
        checkValue("held_first",  first,  2);
        checkValue("held_second", second, 5);
        checkValue("held_rdata",  ReadData, 32'h1);
        checkValue("held_idle",   {31'd0, MemReady}, 1);

        // Reset during the WAIT of a write aborts it
        doAccess(1'b1, 32'h08, 32'h1111_1111, 32'h0, "wr08");
        MemToWrite = 1'b1;
        Address    = 32'h08;
        WriteData  = 32'hA5A5_A5A5;
        @(negedge clk);
        MemToWrite = 1'b0;
        checkValue("abort_inWait", {31'd0, MemReady}, 0);
        reset = 1'b1;
        #1;
        checkValue("abort_ready", {31'd0, MemReady}, 1);
        checkValue("abort_done",  {31'd0, MemDone},  0);
        checkValue("abort_rdata", ReadData, 32'h0);
        checkValue("abort_err",   {31'd0, MemError}, 0);
        @(negedge clk);
        reset = 1'b0;
        doneCnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (MemDone) doneCnt++;
        end
        checkValue("abort_noDone", doneCnt, 0);
        doAccess(1'b0, 32'h08, 32'h1111_1111, 32'h0, "rd08");

        // Zero wait cycles: MemDone one cycle after acceptance
        wr0 = 1'b1; addr0 = 32'h0C; wdata0 = 32'h0000_0077;
        @(negedge clk);
        wr0 = 1'b0; wdata0 = 32'h0;
        checkValue("w0_wrDone",  {31'd0, done0},  1);
        checkValue("w0_wrReady", {31'd0, ready0}, 0);
        @(negedge clk);
        checkValue("w0_wrIdle",  {31'd0, done0},  0);
        checkValue("w0_wrBack",  {31'd0, ready0}, 1);
        rd0 = 1'b1;
        @(negedge clk);
        rd0 = 1'b0;
        checkValue("w0_rdDone",  {31'd0, done0}, 1);
        checkValue("w0_rdData",  rdata0, 32'h0000_0077);
        @(negedge clk);
        checkValue("w0_rdIdle",  {31'd0, done0}, 0);
        checkValue("w0_noErr",   {31'd0, err0},  0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder at the far end of the control unit's memory interface: consumes the `MemToRead`/`MemToWrite` strobes plus address and write data, and completes each access after a fixed, parameterised number of wait cycles. Each completion raises a one-cycle `MemDone` pulse; illegal requests raise a one-cycle `MemError` pulse. The block sits between the datapath (ALU result as address, register file read port as write data) and the write-back mux selected by `MemToReg`.

## Interface
- `DATA_W`, 32: data word width.
- `ADDR_W`, 8: word-index width; depth is 2**ADDR_W words.
- `WAIT_CYCLES`, 1: wait cycles between acceptance and completion, 0..15.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `MemToRead`  in  1  read request.
- `MemToWrite`  in  1  write request.
- `Address`  in  32  byte address.
- `WriteData`  in  DATA_W  store data.
- `ReadData`  out  DATA_W  registered load data; valid from the `MemDone` cycle until the next read completes.
- `MemReady`  out  1  high in IDLE only.
- `MemDone`  out  1  one-cycle completion pulse.
- `MemError`  out  1  one-cycle pulse on a rejected request.

## Operation
- FSM states:
  - IDLE: `MemReady`=1.
  - WAIT: counting wait cycles.
  - RESP: performs the access and pulses `MemDone`.
- Reset values:
  - State IDLE, wait counter 0.
  - `ReadData`=0, `MemReady`=1, `MemDone`=0, `MemError`=0.
  - The storage array is not reset; its contents are undefined until written.
- Acceptance happens in IDLE when exactly one of `MemToRead`/`MemToWrite` is high and the address is legal.
  - On acceptance, latch op, word index `Address[ADDR_W+1:2]` and `WriteData`.
  - Go to WAIT, or directly to RESP if `WAIT_CYCLES`=0.
- Rejection: in IDLE, pulse `MemError`, stay in IDLE and leave memory and `ReadData` unchanged when any of these hold:
  - Both strobes are high.
  - `Address[1:0]` is not 0.
  - `Address[31:ADDR_W+2]` is not 0.
- WAIT: the counter increments each cycle. After `WAIT_CYCLES` cycles in WAIT, go to RESP.
- RESP (one cycle):
  - Write: array[idx] <= latched data.
  - Read: `ReadData` <= array[idx].
  - `MemDone`=1 for this cycle, then return to IDLE.
- Strobes and `Address` are ignored outside IDLE. The requester holds its request until acceptance; inputs may change freely after acceptance because they are latched.
- After `MemDone`, a strobe still high in the following IDLE cycle is a new request. The requester must drop the strobe on seeing `MemDone` unless it is issuing back-to-back accesses.
- Read-after-write to the same word returns the new data, since the write commits in RESP before any later request can be accepted.

## Timing
- Request accepted at edge N:
  - WAIT occupies cycles N+1..N+WAIT_CYCLES.
  - RESP is cycle N+WAIT_CYCLES+1, with `MemDone` high and `ReadData` updated at that edge.
  - IDLE again at N+WAIT_CYCLES+2.
- Throughput is one access per WAIT_CYCLES+2 cycles.
- `MemError` is asserted the cycle after the offending request is sampled. The FSM never leaves IDLE for it.
- `MemReady` is a decode of state and is 0 in WAIT and RESP.
- Reset asserted mid-operation:
  - Return to IDLE immediately and clear the outputs to their reset values.
  - A pending write is discarded; the array is untouched.
  - No `MemDone` is produced for the aborted access.

## Structure
- Shared package `mem_pkg`:
  - State encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Defaults for `DATA_W` and `ADDR_W`.
  - The opcode constant that routes loads and stores, shared with the control unit.
- Sub-module `data_mem_array` holds the storage:
  - Synchronous write with a write enable.
  - Combinational read.
  - No reset.
- The top level holds the FSM, the wait counter, the request latches and the address checker.

## Test plan
- Reset, then write 0xDEADBEEF at address 0x10, then read 0x10 (`WAIT_CYCLES`=1):
  - `MemDone` pulses 2 cycles after each acceptance.
  - `ReadData`=0xDEADBEEF.
  - `MemReady` is low for exactly 2 cycles per access.
- Both strobes high at address 0x20 → `MemError` pulses once, `MemReady` stays 1, and a subsequent read of 0x20 returns the earlier value.
- Misaligned address 0x13, and out-of-range address 0x400 with `ADDR_W`=8:
  - Each produces a `MemError` pulse.
  - No `MemDone`, and no memory change.
- Held strobe and `WAIT_CYCLES` variants:
  - Write to 0x04 with data 0x1 accepted; `WriteData` changed to 0x2 during WAIT → read of 0x04 returns 0x1.
  - Strobe held high → a second access is accepted in the IDLE cycle after `MemDone`.
  - `WAIT_CYCLES`=0 → `MemDone` 1 cycle after acceptance.
- `reset` pulsed during WAIT of a write of 0xA5A5A5A5 to 0x08 (word previously 0x11111111):
  - Outputs return to reset values and no `MemDone` is produced.
  - A later read of 0x08 returns 0x11111111.
